output_line_writer: RTL and testbench

- Downstream of the dense/conv layer compute stage; consumes its stream of 8-bit output activations in row-major order, one element per handshake.
- Packs 8 elements into 64-bit AXI words and issues byte-addressed write requests into three rotating output-line regions (line 0 → 1 → 2 → 0 per output row).
- Partial final words are flushed with a byte strobe.
- Produces row_done and layer_done pulses for the layer controller.

---
 rtl/output_line_writer_pkg.sv | 18 +
 rtl/output_line_writer_lane_packer.sv | 43 ++++
 rtl/output_line_writer.sv | 132 +++++++++++++
 tb/tb_output_line_writer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_line_writer_pkg.sv
// output_line_writer_pkg: NVP_v1 constants, writer state enum and line base helper shared by the output line writer
package output_line_writer_pkg;
  localparam int NVP_AXI_BUS_DATA_BIT_WIDTH = 64;
  localparam int NVP_AXI_BUS_ADDRESS_WIDTH = 32;
  localparam int NVP_ACTIVATION_BIT_WIDTH = 8;
  localparam int NVP_OUTPUT_LINE_0_START_ADDRESS = 6144;
  localparam int NVP_OUTPUT_LINE_1_START_ADDRESS = 8192;
  localparam int NVP_OUTPUT_LINE_2_START_ADDRESS = 10240;
  localparam int NVP_ROW_ELEMENTS_WIDTH = 16;
  localparam int NVP_ROW_COUNT_WIDTH = 10;
  localparam int BYTES_PER_WORD = NVP_AXI_BUS_DATA_BIT_WIDTH / 8;
  localparam int NVP_AXI_BYTE_ACCESS_BITS = $clog2(BYTES_PER_WORD);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} writer_state_e;
  typedef logic [2:0][63:0] line_bases_t;
  function automatic line_bases_t line_bases(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2);
    return {b2, b1, b0};
  endfunction
endpackage

// File: rtl/output_line_writer_lane_packer.sv
// output_line_writer_lane_packer: packs accepted elements into a bus word plus byte strobe (accept_i/row_last_i/data_i in; word_o/strb_o/complete_o out)
module output_line_writer_lane_packer
  import output_line_writer_pkg::*;
#(
  parameter int DATA_W = NVP_AXI_BUS_DATA_BIT_WIDTH,
  parameter int ACT_W = NVP_ACTIVATION_BIT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  input  logic              row_last_i,
  input  logic [ACT_W-1:0]  data_i,
  output logic [DATA_W-1:0] word_o,
  output logic [DATA_W/8-1:0] strb_o,
  output logic              complete_o
);
  localparam int LANES = DATA_W / ACT_W;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int BPL = ACT_W / 8;
  localparam int SW = DATA_W / 8;
  logic [LW-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic [SW-1:0] strb_q, strb_d;
  always_comb begin
    complete_o = accept_i && (lane_q == LW'(LANES - 1) || row_last_i);
    pack_d = ((lane_q == '0) ? '0 : pack_q) | (DATA_W'(data_i) << (lane_q * ACT_W));
    strb_d = ((lane_q == '0) ? '0 : strb_q) | (SW'({BPL{1'b1}}) << (lane_q * BPL));
    lane_d = complete_o ? '0 : lane_q + 1'b1;
    word_o = pack_d;
    strb_o = strb_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      pack_q <= '0;
      strb_q <= '0;
    end else if (accept_i) begin
      lane_q <= lane_d;
      pack_q <= pack_d;
      strb_q <= strb_d;
    end
  end
endmodule

// File: rtl/output_line_writer.sv
// output_line_writer: packs the activation stream (in_*) into word writes (wr_*) over three rotating output lines, with busy/row_done/layer_done status
module output_line_writer
  import output_line_writer_pkg::*;
#(
  parameter int AXI_BUS_DATA_BIT_WIDTH = NVP_AXI_BUS_DATA_BIT_WIDTH,
  parameter int AXI_BUS_ADDRESS_WIDTH = NVP_AXI_BUS_ADDRESS_WIDTH,
  parameter int ACTIVATION_BIT_WIDTH = NVP_ACTIVATION_BIT_WIDTH,
  parameter int AXI_BYTE_ACCESS_BITS = NVP_AXI_BYTE_ACCESS_BITS,
  parameter int OUTPUT_LINE_0_START_ADDRESS = NVP_OUTPUT_LINE_0_START_ADDRESS,
  parameter int OUTPUT_LINE_1_START_ADDRESS = NVP_OUTPUT_LINE_1_START_ADDRESS,
  parameter int OUTPUT_LINE_2_START_ADDRESS = NVP_OUTPUT_LINE_2_START_ADDRESS,
  parameter int ROW_ELEMENTS_WIDTH = NVP_ROW_ELEMENTS_WIDTH,
  parameter int ROW_COUNT_WIDTH = NVP_ROW_COUNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ROW_ELEMENTS_WIDTH-1:0]       cfg_row_elements,
  input  logic [ROW_COUNT_WIDTH-1:0]          cfg_number_of_rows,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ACTIVATION_BIT_WIDTH-1:0]     in_data,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [AXI_BUS_ADDRESS_WIDTH-1:0]    wr_addr,
  output logic [AXI_BUS_DATA_BIT_WIDTH-1:0]   wr_data,
  output logic [AXI_BUS_DATA_BIT_WIDTH/8-1:0] wr_strb,
  output logic                                busy,
  output logic                                row_done,
  output logic                                layer_done
);
  localparam int AW = AXI_BUS_ADDRESS_WIDTH;
  localparam int DW = AXI_BUS_DATA_BIT_WIDTH;
  localparam int SW = DW / 8;
  writer_state_e state_q, state_d;
  logic [ROW_ELEMENTS_WIDTH-1:0] cfg_elems_q, cfg_elems_d, elem_idx_q, elem_idx_d, word_idx_q, word_idx_d;
  logic [ROW_COUNT_WIDTH-1:0] cfg_rows_q, cfg_rows_d, row_idx_q, row_idx_d;
  logic [1:0] line_sel_q, line_sel_d;
  logic wr_valid_q, wr_valid_d, wr_row_end_q, wr_row_end_d;
  logic row_done_q, row_done_d, layer_done_q, layer_done_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d, pk_word;
  logic [SW-1:0] wr_strb_q, wr_strb_d, pk_strb;
  logic accept, hs, last_elem, complete;
  line_bases_t bases;
  assign bases = line_bases(64'(OUTPUT_LINE_0_START_ADDRESS), 64'(OUTPUT_LINE_1_START_ADDRESS), 64'(OUTPUT_LINE_2_START_ADDRESS));
  assign in_ready = (state_q == ST_RUN) && (!wr_valid_q || wr_ready);
  assign accept = in_valid && in_ready;
  assign hs = wr_valid_q && wr_ready;
  assign last_elem = elem_idx_q == cfg_elems_q - 1'b1;
  assign busy = state_q != ST_IDLE;
  assign wr_valid = wr_valid_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_strb = wr_strb_q;
  assign row_done = row_done_q;
  assign layer_done = layer_done_q;
  output_line_writer_lane_packer #(.DATA_W(DW), .ACT_W(ACTIVATION_BIT_WIDTH)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept_i   (accept),
    .row_last_i (last_elem),
    .data_i     (in_data),
    .word_o     (pk_word),
    .strb_o     (pk_strb),
    .complete_o (complete)
  );
  always_comb begin
    state_d = state_q;
    cfg_elems_d = cfg_elems_q;
    cfg_rows_d = cfg_rows_q;
    elem_idx_d = accept ? (last_elem ? '0 : elem_idx_q + 1'b1) : elem_idx_q;
    word_idx_d = complete ? (last_elem ? '0 : word_idx_q + 1'b1) : word_idx_q;
    row_idx_d = (complete && last_elem) ? row_idx_q + 1'b1 : row_idx_q;
    line_sel_d = (complete && last_elem) ? (line_sel_q == 2'd2 ? 2'd0 : line_sel_q + 2'd1) : line_sel_q;
    // a completing word may replace the one handshaking this cycle, so completion wins over the drop
    wr_valid_d = complete ? 1'b1 : (hs ? 1'b0 : wr_valid_q);
    wr_addr_d = complete ? bases[line_sel_q][AW-1:0] + (AW'(word_idx_q) << AXI_BYTE_ACCESS_BITS) : wr_addr_q;
    wr_data_d = complete ? pk_word : wr_data_q;
    wr_strb_d = complete ? pk_strb : wr_strb_q;
    wr_row_end_d = complete ? last_elem : wr_row_end_q;
    row_done_d = hs && wr_row_end_q;
    layer_done_d = state_q == ST_DONE;
    case (state_q)
      ST_IDLE: if (start) begin
        cfg_elems_d = cfg_row_elements;
        cfg_rows_d = cfg_number_of_rows;
        elem_idx_d = '0;
        word_idx_d = '0;
        row_idx_d = '0;
        line_sel_d = '0;
        state_d = (cfg_row_elements == '0 || cfg_number_of_rows == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: state_d = (accept && last_elem && row_idx_q == cfg_rows_q - 1'b1) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = hs ? ST_DONE : ST_DRAIN;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cfg_elems_q <= '0;
      cfg_rows_q <= '0;
      elem_idx_q <= '0;
      word_idx_q <= '0;
      row_idx_q <= '0;
      line_sel_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      wr_row_end_q <= 1'b0;
      row_done_q <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_elems_q <= cfg_elems_d;
      cfg_rows_q <= cfg_rows_d;
      elem_idx_q <= elem_idx_d;
      word_idx_q <= word_idx_d;
      row_idx_q <= row_idx_d;
      line_sel_q <= line_sel_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      wr_row_end_q <= wr_row_end_d;
      row_done_q <= row_done_d;
      layer_done_q <= layer_done_d;
    end
  end
endmodule

// File: tb/tb_output_line_writer.sv
// tb_output_line_writer: directed self-checking bench for output_line_writer
module tb_output_line_writer;
  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, wr_valid, wr_ready, busy, row_done, layer_done;
  logic [15:0] cfg_row_elements;
  logic [9:0] cfg_number_of_rows;
  logic [7:0] in_data;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0] wr_strb;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0, ld_cnt = 0, rd_cyc = 0, ld_cyc = 0;
  int bases[3] = '{6144, 8192, 10240};
  logic [63:0] cap_a[$], cap_d[$], cap_s[$], exp_a[$], exp_d[$], exp_s[$];
  always #5 clk = ~clk;
  output_line_writer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .cfg_row_elements   (cfg_row_elements),
    .cfg_number_of_rows (cfg_number_of_rows),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_strb            (wr_strb),
    .busy               (busy),
    .row_done           (row_done),
    .layer_done         (layer_done)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      cap_a.push_back(64'(wr_addr));
      cap_d.push_back(wr_data);
      cap_s.push_back(64'(wr_strb));
    end
    if (row_done) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
    if (layer_done) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
  end
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] exp_word(int first, int n);
    logic [63:0] w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = 8'(first + k);
    return w;
  endfunction
  task automatic expect_layer(int elems, int rows, int base_val);
    int n;
    exp_a.delete();
    exp_d.delete();
    exp_s.delete();
    for (int r = 0; r < rows; r++)
      for (int w = 0; w * 8 < elems; w++) begin
        n = (elems - w * 8 > 8) ? 8 : elems - w * 8;
        exp_a.push_back(64'(bases[r % 3] + w * 8));
        exp_d.push_back(exp_word(base_val + r * elems + w * 8, n));
        exp_s.push_back(64'((1 << n) - 1));
      end
  endtask
  task automatic clear_caps();
    cap_a.delete();
    cap_d.delete();
    cap_s.delete();
    rd_cnt = 0;
    ld_cnt = 0;
  endtask
  task automatic check_writes(string tag);
    chk({tag, "_count"}, 64'(cap_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++)
      if (i < cap_a.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), cap_a[i], exp_a[i]);
        chk($sformatf("%s_data%0d", tag, i), cap_d[i], exp_d[i]);
        chk($sformatf("%s_strb%0d", tag, i), cap_s[i], exp_s[i]);
      end
  endtask
  task automatic do_start(int e, int r);
    cfg_row_elements = 16'(e);
    cfg_number_of_rows = 10'(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic feed(int n, int base_val);
    int g;
    logic r;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = 8'(base_val + i);
      g = 0;
      do begin
        @(negedge clk);
        r = in_ready;
        @(posedge clk); #1;
        g++;
      end while (!r && g < 200);
      if (!r) begin
        fails++;
        $error("FAIL feed_timeout: element %0d not accepted within %0d cycles", i, g);
        break;
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int g = 0;
    logic seen;
    do begin
      @(negedge clk);
      seen = layer_done;
      @(posedge clk); #1;
      g++;
    end while (!seen && g < 500);
    if (!seen) begin
      fails++;
      $error("FAIL done_timeout: layer_done absent after %0d cycles", g);
    end
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    wr_ready = 1'b1;
    cfg_row_elements = '0;
    cfg_number_of_rows = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_wr_valid", 64'(wr_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_row_done", 64'(row_done), 64'(0));
    chk("rst_layer_done", 64'(layer_done), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", wr_data, 64'(0));
    chk("rst_wr_strb", 64'(wr_strb), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    clear_caps();
    expect_layer(16, 1, 0);
    do_start(16, 1);
    feed(16, 0);
    wait_done();
    chk("t16_w0_data", cap_d.size() > 0 ? cap_d[0] : 64'hx, 64'h0706050403020100);
    check_writes("t16");
    chk("t16_row_done", 64'(rd_cnt), 64'(1));
    chk("t16_layer_done", 64'(ld_cnt), 64'(1));
    chk("t16_done_gap", 64'(ld_cyc - rd_cyc), 64'(1));
    chk("t16_idle", 64'(busy), 64'(0));
    clear_caps();
    expect_layer(20, 4, 0);
    do_start(20, 4);
    feed(80, 0);
    wait_done();
    check_writes("t20x4");
    chk("t20x4_row_done", 64'(rd_cnt), 64'(4));
    clear_caps();
    expect_layer(20, 1, 'h40);
    wr_ready = 1'b1;
    do_start(20, 1);
    fork
      feed(20, 'h40);
      begin
        int g = 0;
        do begin
          @(posedge clk); #1;
          g++;
        end while (!wr_valid && g < 100);
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_valid", 64'(wr_valid), 64'(1));
          chk("stall_in_ready", 64'(in_ready), 64'(0));
          chk("stall_addr", 64'(wr_addr), 64'(6144));
          chk("stall_data", wr_data, exp_word('h40, 8));
          chk("stall_strb", 64'(wr_strb), 64'(8'hFF));
          @(posedge clk); #1;
        end
        wr_ready = 1'b1;
      end
    join
    wait_done();
    check_writes("stall");
    chk("stall_row_done", 64'(rd_cnt), 64'(1));
    clear_caps();
    expect_layer(8, 2, 'h80);
    do_start(8, 2);
    feed(16, 'h80);
    wait_done();
    check_writes("t8x2");
    chk("t8x2_row_done", 64'(rd_cnt), 64'(2));
    clear_caps();
    cfg_row_elements = 16'd5;
    cfg_number_of_rows = 10'd0;
    start = 1'b1;
    @(negedge clk);
    chk("zero_c0_done", 64'(layer_done), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_c1_done", 64'(layer_done), 64'(0));
    chk("zero_c1_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_c2_done", 64'(layer_done), 64'(1));
    chk("zero_c2_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    do_start(0, 3);
    wait_done();
    chk("zero_writes", 64'(cap_a.size()), 64'(0));
    chk("zero_done_cnt", 64'(ld_cnt), 64'(2));
    clear_caps();
    expect_layer(16, 1, 0);
    do_start(16, 1);
    feed(4, 0);
    do_start(8, 3);
    feed(12, 4);
    wait_done();
    check_writes("restart");
    chk("restart_row_done", 64'(rd_cnt), 64'(1));
    do_start(20, 1);
    feed(11, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_valid", 64'(wr_valid), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    clear_caps();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_write", 64'(cap_a.size()), 64'(0));
    expect_layer(16, 1, 0);
    do_start(16, 1);
    feed(16, 0);
    wait_done();
    check_writes("after_rst");
    chk("after_rst_row_done", 64'(rd_cnt), 64'(1));
    chk("after_rst_layer_done", 64'(ld_cnt), 64'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
